// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op bit
// positions (same order as the decode alu_info mul/div slice), FSM state
// encoding and a small sign-extension helper.
package mdu_pkg;

    localparam int OP_WIDTH  = 13;

    localparam int OP_REMUW  = 0;
    localparam int OP_REMW   = 1;
    localparam int OP_REMU   = 2;
    localparam int OP_REM    = 3;
    localparam int OP_DIVUW  = 4;
    localparam int OP_DIVW   = 5;
    localparam int OP_DIVU   = 6;
    localparam int OP_DIV    = 7;
    localparam int OP_MULW   = 8;
    localparam int OP_MULHU  = 9;
    localparam int OP_MULHSU = 10;
    localparam int OP_MULH   = 11;
    localparam int OP_MUL    = 12;

    // Most-negative 32-bit value sign-extended to 64 bits.
    localparam logic [63:0] SX_MIN32 = 64'hFFFF_FFFF_8000_0000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } mdu_state_t;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module mdu_div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic            i_bit,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic            o_qbit
);

    logic [XLEN:0]   w_trial;
    logic [XLEN-1:0] w_diff;

    assign w_trial = {i_rem, i_bit};
    // The remainder stays below the divisor, so a fitting subtraction never
    // needs the top trial bit.
    assign w_diff  = w_trial[XLEN-1:0] - i_divisor;

    // Keep the difference when the divisor fits, otherwise restore.
    always_comb begin
        o_rem  = w_trial[XLEN-1:0];
        o_qbit = 1'b0;
        if (w_trial >= {1'b0, i_divisor}) begin
            o_rem  = w_diff;
            o_qbit = 1'b1;
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV64/RV32 M-extension multiply/divide unit sitting beside the
// execute-stage ALU. One op at a time through a valid/ready handshake; the
// result is held until the consumer accepts it.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | ready for a request; divide special cases resolved here
//   MUL    | shift-add, MUL_UNROLL product bits per cycle
//   DIV    | restoring divide, one quotient bit per cycle
//   FIX    | sign correction, half select, W sign extension
//   DONE   | result valid, waiting for mdu_i_result_ready
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int MUL_UNROLL = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mdu_i_valid,
    output logic                mdu_o_ready,
    input  logic [OP_WIDTH-1:0] mdu_i_op,
    input  logic [XLEN-1:0]     mdu_i_src1,
    input  logic [XLEN-1:0]     mdu_i_src2,
    input  logic                mdu_i_flush,
    output logic                mdu_o_valid,
    output logic [XLEN-1:0]     mdu_o_result,
    input  logic                mdu_i_result_ready
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] MUL_CNT_D = CNT_W'(XLEN / MUL_UNROLL - 1);
    localparam logic [CNT_W-1:0] MUL_CNT_W = CNT_W'(32 / MUL_UNROLL - 1);
    localparam logic [CNT_W-1:0] DIV_CNT_D = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] DIV_CNT_W = CNT_W'(31);

    mdu_state_t r_state;
    mdu_state_t w_state_next;

    logic [CNT_W-1:0]  r_cnt;
    logic              r_is_mul;
    logic              r_is_w;
    logic              r_is_rem;
    logic              r_hi;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [2*XLEN-1:0] r_mcand;
    logic [XLEN-1:0]   r_mplier;
    logic [2*XLEN-1:0] r_prod;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_divisor;
    logic [XLEN-1:0]   r_result;

    // ---------------- request decode ----------------
    logic w_op_onehot, w_op_legal, w_accept;
    logic w_is_w, w_is_mul, w_is_rem, w_hi, w_sgn1, w_sgn2;

    assign w_op_onehot = (mdu_i_op != '0) &&
                         ((mdu_i_op & (mdu_i_op - OP_WIDTH'(1))) == '0);

    assign w_is_w   = mdu_i_op[OP_REMUW] | mdu_i_op[OP_REMW] | mdu_i_op[OP_DIVUW] |
                      mdu_i_op[OP_DIVW]  | mdu_i_op[OP_MULW];
    assign w_is_mul = mdu_i_op[OP_MULW]  | mdu_i_op[OP_MULHU] | mdu_i_op[OP_MULHSU] |
                      mdu_i_op[OP_MULH]  | mdu_i_op[OP_MUL];
    assign w_is_rem = mdu_i_op[OP_REMUW] | mdu_i_op[OP_REMW] | mdu_i_op[OP_REMU] |
                      mdu_i_op[OP_REM];
    assign w_hi     = mdu_i_op[OP_MULHU] | mdu_i_op[OP_MULHSU] | mdu_i_op[OP_MULH];
    assign w_sgn2   = mdu_i_op[OP_REMW]  | mdu_i_op[OP_REM]  | mdu_i_op[OP_DIVW] |
                      mdu_i_op[OP_DIV]   | mdu_i_op[OP_MULW] | mdu_i_op[OP_MULH] |
                      mdu_i_op[OP_MUL];
    // mulhsu treats only rs1 as signed
    assign w_sgn1   = w_sgn2 | mdu_i_op[OP_MULHSU];

    // W ops do not exist on a 32-bit core
    assign w_op_legal = w_op_onehot && ((XLEN == 64) || !w_is_w);
    assign w_accept   = mdu_i_valid && (r_state == S_IDLE) && !mdu_i_flush && w_op_legal;

    // ---------------- operand prep ----------------
    logic [63:0]     w_sx1, w_sx2;
    logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_min_neg;
    logic            w_a_neg, w_b_neg;

    assign w_sx1 = sext32(mdu_i_src1[31:0]);
    assign w_sx2 = sext32(mdu_i_src2[31:0]);

    assign w_a_ext = !w_is_w ? mdu_i_src1 :
                     (w_sgn1 ? w_sx1[XLEN-1:0] : XLEN'(mdu_i_src1[31:0]));
    assign w_b_ext = !w_is_w ? mdu_i_src2 :
                     (w_sgn2 ? w_sx2[XLEN-1:0] : XLEN'(mdu_i_src2[31:0]));

    assign w_a_neg = w_sgn1 & w_a_ext[XLEN-1];
    assign w_b_neg = w_sgn2 & w_b_ext[XLEN-1];
    assign w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
    assign w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;

    // ---------------- divide special cases ----------------
    logic            w_div_zero, w_ovf, w_special;
    logic [XLEN-1:0] w_special_res;

    assign w_min_neg  = w_is_w ? SX_MIN32[XLEN-1:0] : {1'b1, {(XLEN-1){1'b0}}};
    assign w_div_zero = !w_is_mul && (w_b_ext == '0);
    assign w_ovf      = !w_is_mul && w_sgn2 && (w_a_ext == w_min_neg) && (&w_b_ext);
    assign w_special  = w_div_zero | w_ovf;

    // Divide-by-zero and signed overflow have fixed answers, no iteration.
    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            if (w_is_rem)
                w_special_res = w_is_w ? w_sx1[XLEN-1:0] : mdu_i_src1;
            else
                w_special_res = '1;
        end else if (w_ovf && !w_is_rem) begin
            w_special_res = w_a_ext;
        end
    end

    // ---------------- iteration datapath ----------------
    logic [2*XLEN-1:0] w_prod_next;
    logic [XLEN-1:0]   w_rem_next;
    logic              w_qbit;

    // Add the shifted multiplicand for each set multiplier bit this cycle.
    always_comb begin
        w_prod_next = r_prod;
        for (int j = 0; j < MUL_UNROLL; j++) begin
            if (r_mplier[j])
                w_prod_next = w_prod_next + (r_mcand << j);
        end
    end

    mdu_div_step #(
        .XLEN(XLEN)
    ) u_div_step (
        .i_rem     (r_rem),
        .i_bit     (r_quo[XLEN-1]),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_next),
        .o_qbit    (w_qbit)
    );

    // ---------------- result fix-up ----------------
    logic [2*XLEN-1:0] w_prod_signed;
    logic [XLEN-1:0]   w_mul_sel, w_div_sel, w_fix_raw, w_fix_res;
    logic [63:0]       w_fix_sx;

    assign w_prod_signed = r_neg_q ? -r_prod : r_prod;
    assign w_mul_sel     = r_hi ? w_prod_signed[2*XLEN-1:XLEN] : w_prod_signed[XLEN-1:0];
    assign w_div_sel     = r_is_rem ? (r_neg_r ? -r_rem : r_rem)
                                    : (r_neg_q ? -r_quo : r_quo);
    assign w_fix_raw     = r_is_mul ? w_mul_sel : w_div_sel;
    assign w_fix_sx      = sext32(w_fix_raw[31:0]);
    assign w_fix_res     = r_is_w ? w_fix_sx[XLEN-1:0] : w_fix_raw;

    // ---------------- FSM ----------------
    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        w_state_next = r_state;
        if (mdu_i_flush) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_special)
                            w_state_next = S_DONE;
                        else if (w_is_mul)
                            w_state_next = S_MUL;
                        else
                            w_state_next = S_DIV;
                    end
                end
                S_MUL, S_DIV: begin
                    if (r_cnt == '0)
                        w_state_next = S_FIX;
                end
                S_FIX:   w_state_next = S_DONE;
                S_DONE: begin
                    if (mdu_i_result_ready)
                        w_state_next = S_IDLE;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        mdu_o_ready = (r_state == S_IDLE);
        mdu_o_valid = (r_state == S_DONE);
    end

    assign mdu_o_result = r_result;

    // Operand latch, multiply/divide iteration and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_is_mul  <= 1'b0;
            r_is_w    <= 1'b0;
            r_is_rem  <= 1'b0;
            r_hi      <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_prod    <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_mul  <= w_is_mul;
                        r_is_w    <= w_is_w;
                        r_is_rem  <= w_is_rem;
                        r_hi      <= w_hi;
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_neg_r   <= w_a_neg;
                        r_mcand   <= {{XLEN{1'b0}}, w_a_mag};
                        r_mplier  <= w_b_mag;
                        r_prod    <= '0;
                        r_rem     <= '0;
                        // W dividends are left-aligned so 32 steps consume them
                        r_quo     <= w_is_w ? (w_a_mag << (XLEN - 32)) : w_a_mag;
                        r_divisor <= w_b_mag;
                        if (w_is_mul)
                            r_cnt <= w_is_w ? MUL_CNT_W : MUL_CNT_D;
                        else
                            r_cnt <= w_is_w ? DIV_CNT_W : DIV_CNT_D;
                        if (w_special)
                            r_result <= w_special_res;
                    end
                end
                S_MUL: begin
                    r_prod   <= w_prod_next;
                    r_mcand  <= r_mcand << MUL_UNROLL;
                    r_mplier <= r_mplier >> MUL_UNROLL;
                    r_cnt    <= r_cnt - CNT_W'(1);
                end
                S_DIV: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[XLEN-2:0], w_qbit};
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                S_FIX: begin
                    r_result <= w_fix_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter (XLEN=64, MUL_UNROLL=1). Inputs are driven and
// outputs sampled 1ns after the rising edge; "cycle k" is the k-th cycle
// after the request edge.
module tb_mdu_iter;
    import mdu_pkg::*;

    localparam int XLEN = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              mdu_i_valid;
    logic              mdu_o_ready;
    logic [12:0]       mdu_i_op;
    logic [XLEN-1:0]   mdu_i_src1;
    logic [XLEN-1:0]   mdu_i_src2;
    logic              mdu_i_flush;
    logic              mdu_o_valid;
    logic [XLEN-1:0]   mdu_o_result;
    logic              mdu_i_result_ready;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;

    mdu_iter #(
        .XLEN       (XLEN),
        .MUL_UNROLL (1)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .mdu_i_valid        (mdu_i_valid),
        .mdu_o_ready        (mdu_o_ready),
        .mdu_i_op           (mdu_i_op),
        .mdu_i_src1         (mdu_i_src1),
        .mdu_i_src2         (mdu_i_src2),
        .mdu_i_flush        (mdu_i_flush),
        .mdu_o_valid        (mdu_o_valid),
        .mdu_o_result       (mdu_o_result),
        .mdu_i_result_ready (mdu_i_result_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] opv(input int idx);
        logic [12:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string tag, input logic [12:0] op,
                         input logic [63:0] a, input logic [63:0] b);
        mdu_i_valid = 1'b1;
        mdu_i_op    = op;
        mdu_i_src1  = a;
        mdu_i_src2  = b;
        chk({tag, ".ready_at_issue"}, 64'(mdu_o_ready), 64'd1);
        tick();
        mdu_i_valid = 1'b0;
        cyc = 1;
    endtask

    task automatic wait_done(input string tag, input int exp_cyc);
        bit rdy_ok;
        rdy_ok = 1'b1;
        while (mdu_o_valid !== 1'b1 && cyc < 200) begin
            if (mdu_o_ready !== 1'b0) rdy_ok = 1'b0;
            tick();
            cyc++;
        end
        if (mdu_o_ready !== 1'b0) rdy_ok = 1'b0;
        chk({tag, ".valid"}, 64'(mdu_o_valid), 64'd1);
        chk({tag, ".latency"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, ".ready_low"}, 64'(rdy_ok), 64'd1);
    endtask

    task automatic release_result(input string tag);
        mdu_i_result_ready = 1'b1;
        tick();
        mdu_i_result_ready = 1'b0;
        chk({tag, ".idle_after"}, {62'd0, mdu_o_ready, mdu_o_valid}, 64'd2);
    endtask

    task automatic run_op(input string tag, input logic [12:0] op,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int exp_cyc);
        issue(tag, op, a, b);
        wait_done(tag, exp_cyc);
        chk({tag, ".result"}, mdu_o_result, exp);
        release_result(tag);
    endtask

    initial begin
        bit vld_seen;

        rst                = 1'b1;
        mdu_i_valid        = 1'b0;
        mdu_i_op           = '0;
        mdu_i_src1         = '0;
        mdu_i_src2         = '0;
        mdu_i_flush        = 1'b0;
        mdu_i_result_ready = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready",  64'(mdu_o_ready), 64'd1);
        chk("rst.valid",  64'(mdu_o_valid), 64'd0);
        chk("rst.result", mdu_o_result, 64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst.ready", 64'(mdu_o_ready), 64'd1);

        // multiplies
        run_op("mul",    opv(OP_MUL),    64'd3, 64'hFFFF_FFFF_FFFF_FFFB,
               64'hFFFF_FFFF_FFFF_FFF1, 66);
        run_op("mulh",   opv(OP_MULH),   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               64'h4000_0000_0000_0000, 66);
        run_op("mulhu",  opv(OP_MULHU),  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE, 66);
        run_op("mulhsu", opv(OP_MULHSU), 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFF, 66);
        run_op("mulw",   opv(OP_MULW),   64'hABCD_0000_7FFF_FFFF, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFE, 34);

        // divides
        run_op("div",    opv(OP_DIV),    64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFD, 66);
        run_op("rem",    opv(OP_REM),    64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFF, 66);
        run_op("divuw",  opv(OP_DIVUW),  64'h0000_0000_FFFF_FFFE, 64'd2,
               64'h0000_0000_7FFF_FFFF, 34);
        run_op("divw",   opv(OP_DIVW),   64'h1234_5678_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFD, 34);
        run_op("remu",   opv(OP_REMU),   64'd100, 64'd7, 64'd2, 66);

        // special cases
        run_op("divu_by0",  opv(OP_DIVU),  64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("remuw_by0", opv(OP_REMUW), 64'h0000_0000_8000_0001, 64'd0,
               64'hFFFF_FFFF_8000_0001, 1);
        run_op("div_ovf",   opv(OP_DIV),   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 1);
        run_op("remw_ovf",  opv(OP_REMW),  64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'd0, 1);

        // zero-hot and multi-hot requests are ignored
        issue("zero_op", 13'd0, 64'd5, 64'd6);
        chk("zero_op.stay_idle", {62'd0, mdu_o_ready, mdu_o_valid}, 64'd2);
        issue("multi_op", opv(OP_MUL) | opv(OP_DIV), 64'd5, 64'd6);
        chk("multi_op.stay_idle", {62'd0, mdu_o_ready, mdu_o_valid}, 64'd2);

        // request together with flush is not accepted
        mdu_i_flush = 1'b1;
        issue("flush_req", opv(OP_MUL), 64'd5, 64'd6);
        mdu_i_flush = 1'b0;
        chk("flush_req.stay_idle", {62'd0, mdu_o_ready, mdu_o_valid}, 64'd2);

        // flush at cycle 10 of a divide
        issue("flush_div", opv(OP_DIV), 64'd100, 64'd7);
        vld_seen = 1'b0;
        while (cyc < 10) begin
            if (mdu_o_valid !== 1'b0) vld_seen = 1'b1;
            tick();
            cyc++;
        end
        mdu_i_flush = 1'b1;
        tick();
        mdu_i_flush = 1'b0;
        cyc++;
        chk("flush_div.no_valid", 64'(vld_seen), 64'd0);
        chk("flush_div.idle_c11", {62'd0, mdu_o_ready, mdu_o_valid}, 64'd2);
        run_op("after_flush", opv(OP_DIVU), 64'd100, 64'd7, 64'd14, 66);

        // asynchronous reset mid-multiply
        issue("rst_mid", opv(OP_MUL), 64'd9, 64'd9);
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid.ready",  64'(mdu_o_ready), 64'd1);
        chk("rst_mid.valid",  64'(mdu_o_valid), 64'd0);
        chk("rst_mid.result", mdu_o_result, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        run_op("after_rst", opv(OP_MULW), 64'd6, 64'd7, 64'd42, 34);

        // backpressure: result held, new requests refused while in DONE
        issue("bp", opv(OP_REMU), 64'd100, 64'd7);
        wait_done("bp", 66);
        mdu_i_valid = 1'b1;
        mdu_i_op    = opv(OP_MUL);
        mdu_i_src1  = 64'd3;
        mdu_i_src2  = 64'd3;
        for (int k = 0; k < 5; k++) begin
            chk("bp.hold_valid",  64'(mdu_o_valid), 64'd1);
            chk("bp.hold_result", mdu_o_result, 64'd2);
            chk("bp.hold_ready",  64'(mdu_o_ready), 64'd0);
            tick();
        end
        mdu_i_valid = 1'b0;
        release_result("bp");
        tick();
        chk("bp.no_late_accept", {62'd0, mdu_o_ready, mdu_o_valid}, 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
